// File: rtl/text_writer_if.sv
// Byte stream in and text RAM write port out of the text writer.
// The master side is the writer itself; the slave side feeds bytes and takes writes.
interface text_writer_if #(
   parameter int addr_width = 12,
   parameter int data_width = 8
);
   logic [7:0]            din;
   logic                  din_valid;
   logic                  din_ready;
   logic [addr_width-1:0] waddr;
   logic [data_width-1:0] wdata;
   logic                  write_en;

   modport master (
      input  din, din_valid,
      output din_ready, waddr, wdata, write_en
   );

   modport slave (
      output din, din_valid,
      input  din_ready, waddr, wdata, write_en
   );
endinterface

// File: rtl/text_writer.sv
// Turns an ASCII byte stream into text RAM writes with a tracked cursor,
// handling CR/LF/BS/FF and blanking lines or the whole screen by sequential fill.
module text_writer #(
   parameter int COLS           = 80,
   parameter int ROWS           = 30,
   parameter int addr_width     = 12,
   parameter int data_width     = 8,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          rstn,
   text_writer_if.master bus,
   output logic [6:0]    cur_x,
   output logic [4:0]    cur_y,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

   localparam state_t                RST_STATE = CLEAR_ON_RESET ? CLR_ALL : IDLE;
   localparam logic [addr_width-1:0] COLS_A    = addr_width'(COLS);
   localparam logic [addr_width-1:0] LINE_END  = addr_width'(COLS - 1);
   localparam logic [addr_width-1:0] SCR_END   = addr_width'(COLS * ROWS - 1);
   localparam logic [6:0]            LAST_X    = 7'(COLS - 1);
   localparam logic [4:0]            LAST_Y    = 5'(ROWS - 1);
   localparam logic [data_width-1:0] SPACE     = data_width'(8'h20);

   state_t                state, state_n;
   logic [6:0]            col, col_n, col_dec;
   logic [4:0]            row, row_n;
   logic [addr_width-1:0] line_base, lb_n;
   logic [addr_width-1:0] cnt, cnt_n;
   logic [addr_width-1:0] waddr_q, waddr_n;
   logic [data_width-1:0] wdata_q, wdata_n;
   logic                  we_q, we_n;
   logic                  rdy_q, rdy_n;
   logic                  busy_q, busy_n;
   logic                  adv;

   assign col_dec = col - 7'd1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= RST_STATE;
         col       <= '0;
         row       <= '0;
         line_base <= '0;
         cnt       <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_n;
         col       <= col_n;
         row       <= row_n;
         line_base <= lb_n;
         cnt       <= cnt_n;
         waddr_q   <= waddr_n;
         wdata_q   <= wdata_n;
         we_q      <= we_n;
         rdy_q     <= rdy_n;
         busy_q    <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      lb_n    = line_base;
      cnt_n   = cnt;
      waddr_n = waddr_q;
      wdata_n = wdata_q;
      we_n    = 1'b0;
      rdy_n   = 1'b0;
      busy_n  = 1'b1;
      adv     = 1'b0;
      case (state)
         IDLE: begin
            rdy_n  = 1'b1;
            busy_n = 1'b0;
            if (bus.din_valid && rdy_q) begin
               if (bus.din == 8'h0C) begin
                  state_n = CLR_ALL;
                  col_n   = '0;
                  row_n   = '0;
                  lb_n    = '0;
                  cnt_n   = '0;
               end else if (bus.din == 8'h0D) begin
                  col_n = '0;
               end else if (bus.din == 8'h0A) begin
                  col_n = '0;
                  adv   = 1'b1;
               end else if (bus.din == 8'h08) begin
                  // no wrap back to the previous line at column 0
                  if (col != 7'd0) begin
                     col_n   = col_dec;
                     we_n    = 1'b1;
                     waddr_n = line_base + addr_width'(col_dec);
                     wdata_n = SPACE;
                  end
               end else if (bus.din >= 8'h20 && bus.din != 8'h7F) begin
                  we_n    = 1'b1;
                  waddr_n = line_base + addr_width'(col);
                  wdata_n = data_width'(bus.din);
                  if (col == LAST_X) begin
                     col_n = '0;
                     adv   = 1'b1;
                  end else begin
                     col_n = col + 7'd1;
                  end
               end
               // new row is blanked right after, wrapping to the top (no scroll)
               if (adv) begin
                  state_n = CLR_LINE;
                  cnt_n   = '0;
                  if (row == LAST_Y) begin
                     row_n = '0;
                     lb_n  = '0;
                  end else begin
                     row_n = row + 5'd1;
                     lb_n  = line_base + COLS_A;
                  end
               end
               if (state_n != IDLE) begin
                  rdy_n  = 1'b0;
                  busy_n = 1'b1;
               end
            end
         end
         CLR_LINE: begin
            we_n    = 1'b1;
            waddr_n = line_base + cnt;
            wdata_n = SPACE;
            cnt_n   = cnt + 1'b1;
            if (cnt == LINE_END) state_n = IDLE;
         end
         CLR_ALL: begin
            we_n    = 1'b1;
            waddr_n = cnt;
            wdata_n = SPACE;
            cnt_n   = cnt + 1'b1;
            if (cnt == SCR_END) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.din_ready = rdy_q;
   assign bus.waddr     = waddr_q;
   assign bus.wdata     = wdata_q;
   assign bus.write_en  = we_q;
   assign cur_x         = col;
   assign cur_y         = row;
   assign busy          = busy_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer on a 4x3 screen with clear-on-reset.
module tb_text_writer;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [6:0] cur_x;
   logic [4:0] cur_y;
   logic       busy;
   int         n_tests = 0;
   int         n_fail  = 0;

   text_writer_if #(.addr_width(12), .data_width(8)) bus();

   text_writer #(
      .COLS(4), .ROWS(3), .addr_width(12), .data_width(8), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input int a, input int d);
      chk({tag, "_we"}, 32'(bus.write_en), 1);
      chk({tag, "_addr"}, 32'(bus.waddr), a);
      chk({tag, "_data"}, 32'(bus.wdata), d);
   endtask

   task automatic chk_cur(input string tag, input int x, input int y);
      chk({tag, "_x"}, 32'(cur_x), x);
      chk({tag, "_y"}, 32'(cur_y), y);
   endtask

   // present a byte, wait for ready, and return just after the accept edge
   task automatic send(input string tag, input logic [7:0] b);
      int t;
      bus.din       = b;
      bus.din_valid = 1'b1;
      t = 0;
      while (bus.din_ready !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      chk({tag, "_ready"}, 32'(bus.din_ready), 1);
      step();
      bus.din_valid = 1'b0;
   endtask

   task automatic clear_writes(input string tag, input int base, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk_wr($sformatf("%s_c%0d", tag, i), base + i, 8'h20);
         chk({tag, "_busy"}, 32'(busy), 1);
         chk({tag, "_nrdy"}, 32'(bus.din_ready), 0);
      end
   endtask

   task automatic clear_done(input string tag);
      step();
      chk({tag, "_we0"}, 32'(bus.write_en), 0);
      chk({tag, "_rdy"}, 32'(bus.din_ready), 1);
      chk({tag, "_busy0"}, 32'(busy), 0);
   endtask

   initial begin
      bus.din       = 8'h00;
      bus.din_valid = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(bus.write_en), 0);
      chk("rst_addr", 32'(bus.waddr), 0);
      chk("rst_data", 32'(bus.wdata), 0);
      chk("rst_rdy", 32'(bus.din_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk_cur("rst_cur", 0, 0);
      #3 rstn = 1'b1;
      chk("rel_busy", 32'(busy), 0);
      clear_writes("pwr", 0, 12);
      clear_done("pwr");
      chk_cur("pwr_cur", 0, 0);

      // back-to-back printable bytes
      send("A", 8'h41);  chk_wr("A", 0, 8'h41);
      send("B", 8'h42);  chk_wr("B", 1, 8'h42);
      chk_cur("AB_cur", 2, 0);
      send("cr0", 8'h0D); chk("cr0_we", 32'(bus.write_en), 0);
      chk_cur("cr0_cur", 0, 0);

      // full line wraps, held byte waits out the line clear
      send("W", 8'h57);  chk_wr("W", 0, 8'h57);
      send("X", 8'h58);  chk_wr("X", 1, 8'h58);
      send("Y", 8'h59);  chk_wr("Y", 2, 8'h59);
      send("Z", 8'h5A);  chk_wr("Z", 3, 8'h5A);
      chk("Z_nrdy", 32'(bus.din_ready), 0);
      chk_cur("Z_cur", 0, 1);
      bus.din       = 8'h4B;
      bus.din_valid = 1'b1;
      clear_writes("l1", 4, 4);
      clear_done("l1");
      step();
      bus.din_valid = 1'b0;
      chk_wr("K", 4, 8'h4B);
      chk_cur("K_cur", 1, 1);
      send("bs1", 8'h08); chk_wr("bs1", 4, 8'h20);
      chk_cur("bs1_cur", 0, 1);

      // LF down to the last row, then LF wraps to row 0
      send("lf2", 8'h0A); chk("lf2_we", 32'(bus.write_en), 0);
      chk_cur("lf2_cur", 0, 2);
      clear_writes("l2", 8, 4);
      clear_done("l2");
      send("lf0", 8'h0A); chk_cur("lf0_cur", 0, 0);
      clear_writes("l0", 0, 4);
      clear_done("l0");

      // Q, BS, BS
      send("Q", 8'h51);   chk_wr("Q", 0, 8'h51);
      send("bs2", 8'h08); chk_wr("bs2", 0, 8'h20);
      chk_cur("bs2_cur", 0, 0);
      send("bs3", 8'h08); chk("bs3_we", 32'(bus.write_en), 0);
      chk_cur("bs3_cur", 0, 0);

      // CR from (3,1), ignored control codes
      send("lf1", 8'h0A); chk_cur("lf1_cur", 0, 1);
      clear_writes("l1b", 4, 4);
      clear_done("l1b");
      send("a", 8'h61); chk_wr("a", 4, 8'h61);
      send("b", 8'h62); chk_wr("b", 5, 8'h62);
      send("c", 8'h63); chk_wr("c", 6, 8'h63);
      chk_cur("abc_cur", 3, 1);
      send("cr1", 8'h0D); chk("cr1_we", 32'(bus.write_en), 0);
      chk_cur("cr1_cur", 0, 1);
      send("del", 8'h7F); chk("del_we", 32'(bus.write_en), 0);
      send("soh", 8'h01); chk("soh_we", 32'(bus.write_en), 0);
      chk_cur("ign_cur", 0, 1);
      chk("ign_rdy", 32'(bus.din_ready), 1);

      // FF mid-line, reset during the clear
      send("x", 8'h78); chk_wr("x", 4, 8'h78);
      send("ff", 8'h0C);
      chk("ff_we", 32'(bus.write_en), 0);
      chk("ff_busy", 32'(busy), 1);
      chk("ff_nrdy", 32'(bus.din_ready), 0);
      chk_cur("ff_cur", 0, 0);
      clear_writes("ffc", 0, 5);
      #2 rstn = 1'b0;
      #1;
      chk("arst_we", 32'(bus.write_en), 0);
      chk("arst_addr", 32'(bus.waddr), 0);
      chk("arst_data", 32'(bus.wdata), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_rdy", 32'(bus.din_ready), 0);
      chk_cur("arst_cur", 0, 0);
      @(posedge clk);
      #3 rstn = 1'b1;
      clear_writes("rclr", 0, 12);
      clear_done("rclr");

      // last cell of the screen wraps to (0,0) and blanks row 0 without a gap
      send("lfa", 8'h0A); clear_writes("la", 4, 4);  clear_done("la");
      send("lfb", 8'h0A); clear_writes("lb", 8, 4);  clear_done("lb");
      send("C0", 8'h41); chk_wr("C0", 8, 8'h41);
      send("C1", 8'h42); chk_wr("C1", 9, 8'h42);
      send("C2", 8'h43); chk_wr("C2", 10, 8'h43);
      send("C3", 8'h44); chk_wr("C3", 11, 8'h44);
      chk_cur("end_cur", 0, 0);
      clear_writes("lw", 0, 4);
      clear_done("lw");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
